// File: rtl/cam_capture_crop.sv
// Camera capture stage: RGB565 byte pairs to RGB444 pixels, written to a 128x128 crop of a QVGA frame.
// Optional build macro CAM_CAPTURE_TESTPAT_EN adds input tp_en for a position-coded test pattern.
module cam_capture_crop #(
    parameter int C_SRC_COLS    = 320,
    parameter int C_SRC_ROWS    = 240,
    parameter int C_IMG_COLS    = 128,
    parameter int C_IMG_ROWS    = 128,
    parameter int C_COL_OFS     = 96,
    parameter int C_ROW_OFS     = 56,
    parameter int C_NB_IMG_PXLS = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cam_vsync,
    input  logic                     cam_href,
    input  logic                     cam_byte_en,
    input  logic [7:0]               cam_data,
`ifdef CAM_CAPTURE_TESTPAT_EN
    input  logic                     tp_en,
`endif
    output logic                     wea,
    output logic [C_NB_IMG_PXLS-1:0] addra,
    output logic [11:0]              dina,
    output logic                     frame_done,
    output logic                     line_err
);
    localparam int C_COL_W    = $clog2(C_SRC_COLS + 1);
    localparam int C_ROW_W    = $clog2(C_SRC_ROWS + 1);
    localparam int C_COL_BITS = $clog2(C_IMG_COLS);
    localparam int C_ROW_BITS = C_NB_IMG_PXLS - C_COL_BITS;

    localparam logic [1:0] S_SYNC   = 2'd0;
    localparam logic [1:0] S_VBLANK = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

    logic [1:0]               r_state;
    logic [C_COL_W-1:0]       r_src_col;
    logic [C_ROW_W-1:0]       r_src_row;
    logic                     r_phase;
    logic [6:0]               r_hi;
    logic                     r_href_d;
    logic                     r_wea;
    logic [C_NB_IMG_PXLS-1:0] r_addra;
    logic [11:0]              r_dina;
    logic                     r_frame_done;
    logic                     r_line_err;

    logic [C_COL_W-1:0]       w_col_rel;
    logic [C_ROW_W-1:0]       w_row_rel;
    logic                     w_in_win;
    logic [C_NB_IMG_PXLS-1:0] w_addr;
    logic [11:0]              w_cam_px;
    logic [11:0]              w_px;

    // Unsigned wrap makes the lower window bound fall out of a single compare.
    assign w_col_rel = r_src_col - C_COL_W'(C_COL_OFS);
    assign w_row_rel = r_src_row - C_ROW_W'(C_ROW_OFS);
    assign w_in_win  = (w_col_rel < C_COL_W'(C_IMG_COLS)) && (w_row_rel < C_ROW_W'(C_IMG_ROWS));
    assign w_addr    = {w_row_rel[C_ROW_BITS-1:0], w_col_rel[C_COL_BITS-1:0]};

    // Only the high-byte bits that survive the RGB444 reduction are kept in r_hi.
    assign w_cam_px = {r_hi[6:3], r_hi[2:0], cam_data[7], cam_data[4:1]};

`ifdef CAM_CAPTURE_TESTPAT_EN
    assign w_px = tp_en ? {w_col_rel[6:3], w_row_rel[6:3], 4'hF} : w_cam_px;
`else
    assign w_px = w_cam_px;
`endif

    always_ff @(posedge clk) begin
        r_href_d     <= cam_href;
        r_wea        <= 1'b0;
        r_frame_done <= 1'b0;
        if (rst) begin
            r_state    <= S_SYNC;
            r_src_col  <= '0;
            r_src_row  <= '0;
            r_phase    <= 1'b0;
            r_hi       <= '0;
            r_href_d   <= 1'b0;
            r_addra    <= '0;
            r_dina     <= '0;
            r_line_err <= 1'b0;
        end else begin
            case (r_state)
                S_SYNC: begin
                    if (cam_vsync)
                        r_state <= S_VBLANK;
                end
                S_VBLANK: begin
                    if (!cam_vsync) begin
                        r_state   <= S_ACTIVE;
                        r_src_col <= '0;
                        r_src_row <= '0;
                        r_phase   <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (cam_vsync) begin
                        // Frame end also terminates any line still in progress.
                        r_frame_done <= 1'b1;
                        r_state      <= S_VBLANK;
                        r_src_col    <= '0;
                        r_phase      <= 1'b0;
                        if (r_phase)
                            r_line_err <= 1'b1;
                    end else if (r_href_d && !cam_href) begin
                        if (r_src_row != C_ROW_W'(C_SRC_ROWS))
                            r_src_row <= r_src_row + 1'b1;
                        r_src_col <= '0;
                        r_phase   <= 1'b0;
                        if (r_phase)
                            r_line_err <= 1'b1;
                    end else if (cam_href && cam_byte_en) begin
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
                            r_hi <= {cam_data[7:4], cam_data[2:0]};
                        end else if (r_src_col == C_COL_W'(C_SRC_COLS)) begin
                            r_line_err <= 1'b1;
                        end else begin
                            r_src_col <= r_src_col + 1'b1;
                            if (w_in_win) begin
                                r_wea   <= 1'b1;
                                r_addra <= w_addr;
                                r_dina  <= w_px;
                            end
                        end
                    end
                end
                default: r_state <= S_SYNC;
            endcase
        end
    end

    assign wea        = r_wea;
    assign addra      = r_addra;
    assign dina       = r_dina;
    assign frame_done = r_frame_done;
    assign line_err   = r_line_err;
endmodule
